pc_unit: RTL and testbench

//  Parametrised program-counter unit for the MIPS fetch stage; next generation of the basic PC register.

---
 rtl/pc_pkg.sv | 33 +++
 rtl/pc_if.sv | 33 +++
 rtl/pc_ras.sv | 70 +++++++
 rtl/pc_unit.sv | 150 +++++++++++++++
 tb/tb_pc_unit.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared types, default vectors and alignment helpers for the MIPS fetch-stage PC unit.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_ST_BOOT = 2'd0,
        PC_ST_RUN  = 2'd1,
        PC_ST_HALT = 2'd2
    } pc_state_e;

    localparam logic [31:0] PC_DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] PC_DEF_EXC_VECTOR   = 32'h8000_0180;
    localparam int          PC_ALIGN_MAX_W      = 64;

    // Callers zero-extend their value to PC_ALIGN_MAX_W so one helper serves every WIDTH.
    function automatic logic [PC_ALIGN_MAX_W-1:0] pc_align(
        input logic [PC_ALIGN_MAX_W-1:0] value,
        input int unsigned               align_bits
    );
        logic [PC_ALIGN_MAX_W-1:0] mask;
        mask = (64'd1 << align_bits) - 64'd1;
        return value & ~mask;
    endfunction

    function automatic logic pc_misaligned(
        input logic [PC_ALIGN_MAX_W-1:0] value,
        input int unsigned               align_bits
    );
        logic [PC_ALIGN_MAX_W-1:0] mask;
        mask = (64'd1 << align_bits) - 64'd1;
        return |(value & mask);
    endfunction

endpackage

// File: rtl/pc_if.sv
// Control/branch-side bundle of the PC unit: the control side drives the master modport,
// the PC unit sits on the slave modport.
interface pc_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] pc_new_value;
    logic             pc_write_sig;
    logic             pc_exc;
    logic             pc_eret;
    logic             pc_stall;
    logic             pc_halt;
    logic             pc_resume;
    logic             pc_ras_push;
    logic             pc_ras_pop;
    logic [WIDTH-1:0] pc_out;
    logic             pc_valid;
    logic [WIDTH-1:0] pc_epc;
    logic             pc_misalign;
    logic             pc_ras_empty;
    logic             pc_ras_uflow;

    modport master (
        output pc_new_value, pc_write_sig, pc_exc, pc_eret, pc_stall,
               pc_halt, pc_resume, pc_ras_push, pc_ras_pop,
        input  pc_out, pc_valid, pc_epc, pc_misalign, pc_ras_empty, pc_ras_uflow
    );

    modport slave (
        input  pc_new_value, pc_write_sig, pc_exc, pc_eret, pc_stall,
               pc_halt, pc_resume, pc_ras_push, pc_ras_pop,
        output pc_out, pc_valid, pc_epc, pc_misalign, pc_ras_empty, pc_ras_uflow
    );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: a full push overwrites the oldest entry, and a push
// paired with an effective pop replaces the top in place.
module pc_ras #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic [WIDTH-1:0] top_o,
    output logic             empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] wr_idx_s;
    logic             wr_en_s;
    logic             pop_ok_s;

    assign pop_ok_s = pop_i && (cnt_q != {CNT_W{1'b0}});
    assign top_o    = mem_q[ptr_q];
    assign empty_o  = (cnt_q == {CNT_W{1'b0}});

    // Pointer/count next state and write slot selection
    always_comb begin
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        wr_en_s  = 1'b0;
        wr_idx_s = ptr_q;
        if (push_i && pop_ok_s) begin
            wr_en_s = 1'b1;
        end else if (push_i) begin
            ptr_d    = ptr_q + PTR_W'(1);
            wr_idx_s = ptr_q + PTR_W'(1);
            wr_en_s  = 1'b1;
            if (cnt_q != CNT_W'(DEPTH)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else if (pop_ok_s) begin
            ptr_d = ptr_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Stack storage and pointers
    always_ff @(negedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q <= {PTR_W{1'b0}};
            cnt_q <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            if (wr_en_s) begin
                mem_q[wr_idx_s] <= push_data_i;
            end
        end
    end
endmodule

// File: rtl/pc_unit.sv
// Program-counter unit for the MIPS fetch stage with BOOT/RUN/HALT control.
// Define PC_RAS_EN to include the return-address stack (pc_ras).
module pc_unit
    import pc_pkg::*;
#(
    parameter int                WIDTH        = 32,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = WIDTH'(PC_DEF_RESET_VECTOR),
    parameter logic [WIDTH-1:0]  EXC_VECTOR   = WIDTH'(PC_DEF_EXC_VECTOR),
    parameter int                INC          = 4,
    parameter int unsigned       ALIGN_BITS   = 2,
    parameter int                RAS_DEPTH    = 4,
    parameter int                RET_OFFSET   = 8
) (
    input  logic pc_clk,
    input  logic pc_rst_n,
    pc_if.slave  bus
);
`ifdef PC_RAS_EN
    localparam bit RAS_EN_C = 1'b1;
`else
    localparam bit RAS_EN_C = 1'b0;
`endif

    pc_state_e                 state_q, state_d;
    logic [WIDTH-1:0]          pc_q, pc_d;
    logic [WIDTH-1:0]          epc_q, epc_d;
    logic                      valid_q, valid_d;
    logic                      misalign_q, misalign_d;
    logic                      uflow_q, uflow_d;
    logic [PC_ALIGN_MAX_W-1:0] nv_wide_s;
    logic [WIDTH-1:0]          nv_aligned_s;
    logic                      nv_misaligned_s;
    logic [WIDTH-1:0]          ras_top_s;
    logic                      ras_empty_s;
    logic                      pop_take_s;
    logic                      pop_req_s;

    assign nv_wide_s       = PC_ALIGN_MAX_W'(bus.pc_new_value);
    assign nv_aligned_s    = WIDTH'(pc_align(nv_wide_s, ALIGN_BITS));
    assign nv_misaligned_s = pc_misaligned(nv_wide_s, ALIGN_BITS);

    // A pop only reaches the stack when nothing of higher priority claims the edge.
    assign pop_req_s  = (state_q == PC_ST_RUN) && bus.pc_ras_pop && !bus.pc_stall &&
                        !bus.pc_exc && !bus.pc_eret && !bus.pc_write_sig;
    assign pop_take_s = pop_req_s && !ras_empty_s;

`ifdef PC_RAS_EN
    logic push_take_s;
    assign push_take_s = (state_q == PC_ST_RUN) && bus.pc_ras_push && !bus.pc_stall &&
                         !bus.pc_exc && !bus.pc_eret;

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i       (pc_clk),
        .rst_n_i     (pc_rst_n),
        .push_i      (push_take_s),
        .pop_i       (pop_take_s),
        .push_data_i (pc_q + WIDTH'(RET_OFFSET)),
        .top_o       (ras_top_s),
        .empty_o     (ras_empty_s)
    );
`else
    assign ras_top_s   = {WIDTH{1'b0}};
    assign ras_empty_s = 1'b1;
`endif

    // Next-state and PC selection, highest priority first
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epc_d      = epc_q;
        valid_d    = valid_q;
        misalign_d = 1'b0;
        uflow_d    = RAS_EN_C && pop_req_s && ras_empty_s;
        case (state_q)
            PC_ST_BOOT: begin
                state_d = PC_ST_RUN;
                valid_d = 1'b1;
            end
            PC_ST_RUN: begin
                if (bus.pc_exc) begin
                    epc_d = pc_q;
                    pc_d  = EXC_VECTOR;
                end else if (bus.pc_eret) begin
                    pc_d = epc_q;
                end else if (bus.pc_write_sig) begin
                    pc_d       = nv_aligned_s;
                    misalign_d = nv_misaligned_s;
                end else if (pop_take_s) begin
                    pc_d = ras_top_s;
                end else if (bus.pc_halt) begin
                    state_d = PC_ST_HALT;
                    valid_d = 1'b0;
                end else if (bus.pc_stall) begin
                    pc_d = pc_q;
                end else begin
                    pc_d = pc_q + WIDTH'(INC);
                end
            end
            PC_ST_HALT: begin
                if (bus.pc_exc) begin
                    epc_d   = pc_q;
                    pc_d    = EXC_VECTOR;
                    state_d = PC_ST_RUN;
                    valid_d = 1'b1;
                end else if (bus.pc_resume) begin
                    state_d = PC_ST_RUN;
                    valid_d = 1'b1;
                end else if (bus.pc_write_sig) begin
                    pc_d       = nv_aligned_s;
                    misalign_d = nv_misaligned_s;
                end else begin
                    pc_d = pc_q;
                end
            end
            default: begin
                state_d = PC_ST_BOOT;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(negedge pc_clk or negedge pc_rst_n) begin
        if (!pc_rst_n) begin
            state_q    <= PC_ST_BOOT;
            pc_q       <= RESET_VECTOR;
            epc_q      <= {WIDTH{1'b0}};
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            uflow_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
            uflow_q    <= uflow_d;
        end
    end

    assign bus.pc_out       = pc_q;
    assign bus.pc_valid     = valid_q;
    assign bus.pc_epc       = epc_q;
    assign bus.pc_misalign  = misalign_q;
    assign bus.pc_ras_empty = ras_empty_s;
    assign bus.pc_ras_uflow = uflow_q;
endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vector table, hand sequences for reset and the
// return-address stack, then randomized stimulus against a queue-based reference model.
module tb_pc_unit;
    localparam logic [31:0] RST_V = 32'h0000_0000;
    localparam logic [31:0] EXC_V = 32'h8000_0180;
    localparam int          DEPTH = 4;
`ifdef PC_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    typedef struct {
        logic        wr;
        logic [31:0] nv;
        logic        exc, eret, stall, halt, resume, push, pop;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_epc;
        logic        e_mis;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    pc_if #(.WIDTH(32)) bus ();

    pc_unit dut (
        .pc_clk   (clk),
        .pc_rst_n (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    int          m_state;   // 0 boot, 1 run, 2 halt
    logic [31:0] m_pc, m_epc;
    logic        m_valid, m_mis, m_uf;
    logic [31:0] m_ras[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [31:0] nv, input logic exc,
                                input logic eret, input logic stall, input logic halt,
                                input logic resume, input logic [31:0] e_pc,
                                input logic e_valid, input logic [31:0] e_epc,
                                input logic e_mis);
        vec_t v;
        v.wr = wr; v.nv = nv; v.exc = exc; v.eret = eret; v.stall = stall;
        v.halt = halt; v.resume = resume; v.push = 1'b0; v.pop = 1'b0;
        v.e_pc = e_pc; v.e_valid = e_valid; v.e_epc = e_epc; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic drive(input logic wr, input logic [31:0] nv, input logic exc,
                         input logic eret, input logic stall, input logic halt,
                         input logic resume, input logic push, input logic pop);
        bus.pc_write_sig = wr;   bus.pc_new_value = nv; bus.pc_exc = exc;
        bus.pc_eret = eret;      bus.pc_stall = stall;  bus.pc_halt = halt;
        bus.pc_resume = resume;  bus.pc_ras_push = push; bus.pc_ras_pop = pop;
    endtask

    // one active (negative) edge, then sample at the following rising edge
    task automatic step();
        @(negedge clk);
        @(posedge clk);
    endtask

    task automatic model_reset();
        m_state = 0; m_pc = RST_V; m_epc = 32'h0; m_valid = 1'b0;
        m_mis = 1'b0; m_uf = 1'b0; m_ras.delete();
    endtask

    task automatic model_edge(input logic wr, input logic [31:0] nv, input logic exc,
                              input logic eret, input logic stall, input logic halt,
                              input logic resume, input logic push, input logic pop);
        logic [31:0] old_pc;
        logic        popped;
        old_pc = m_pc; popped = 1'b0; m_mis = 1'b0; m_uf = 1'b0;
        if (m_state == 0) begin
            m_state = 1; m_valid = 1'b1;
        end else if (m_state == 1) begin
            if (exc) begin
                m_epc = old_pc; m_pc = EXC_V;
            end else if (eret) begin
                m_pc = m_epc;
            end else if (wr) begin
                m_pc = {nv[31:2], 2'b00}; m_mis = (nv[1:0] != 2'b00);
            end else begin
                if (pop && !stall && RAS_EN && m_ras.size() > 0) begin
                    m_pc = m_ras[m_ras.size() - 1]; popped = 1'b1;
                end else begin
                    if (pop && !stall && RAS_EN) m_uf = 1'b1;
                    if (halt) begin
                        m_state = 2; m_valid = 1'b0;
                    end else if (!stall) begin
                        m_pc = old_pc + 32'd4;
                    end
                end
            end
            if (RAS_EN && push && !stall && !exc && !eret) begin
                if (popped) begin
                    m_ras[m_ras.size() - 1] = old_pc + 32'd8;
                end else begin
                    m_ras.push_back(old_pc + 32'd8);
                    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                end
            end else if (popped) begin
                void'(m_ras.pop_back());
            end
        end else begin
            if (exc) begin
                m_epc = old_pc; m_pc = EXC_V; m_state = 1; m_valid = 1'b1;
            end else if (resume) begin
                m_state = 1; m_valid = 1'b1;
            end else if (wr) begin
                m_pc = {nv[31:2], 2'b00}; m_mis = (nv[1:0] != 2'b00);
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pc"},    bus.pc_out,       m_pc);
        chk({tag, ".valid"}, bus.pc_valid,     m_valid);
        chk({tag, ".epc"},   bus.pc_epc,       m_epc);
        chk({tag, ".mis"},   bus.pc_misalign,  m_mis);
        chk({tag, ".empty"}, bus.pc_ras_empty, (m_ras.size() == 0));
        chk({tag, ".uflow"}, bus.pc_ras_uflow, m_uf);
    endtask

    task automatic ras_step(input logic push, input logic pop, input logic [31:0] e_pc,
                            input logic e_empty, input logic e_uf, input string tag);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, push, pop);
        step();
        chk({tag, ".pc"},    bus.pc_out,       e_pc);
        chk({tag, ".empty"}, bus.pc_ras_empty, e_empty);
        chk({tag, ".uflow"}, bus.pc_ras_uflow, e_uf);
    endtask

    vec_t tbl[23];

    initial begin
        tbl[0]  = mk(0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        1, 32'h0,    0);
        tbl[1]  = mk(0, 32'h0,        0, 0, 0, 0, 0, 32'h4,        1, 32'h0,    0);
        tbl[2]  = mk(0, 32'h0,        0, 0, 0, 0, 0, 32'h8,        1, 32'h0,    0);
        tbl[3]  = mk(1, 32'h1003,     0, 0, 1, 0, 0, 32'h1000,     1, 32'h0,    1);
        tbl[4]  = mk(0, 32'h0,        0, 0, 0, 0, 0, 32'h1004,     1, 32'h0,    0);
        tbl[5]  = mk(1, 32'h40,       0, 0, 0, 0, 0, 32'h40,       1, 32'h0,    0);
        tbl[6]  = mk(0, 32'h0,        1, 0, 0, 0, 0, EXC_V,        1, 32'h40,   0);
        tbl[7]  = mk(0, 32'h0,        0, 0, 0, 0, 0, 32'h80000184, 1, 32'h40,   0);
        tbl[8]  = mk(0, 32'h0,        0, 1, 0, 0, 0, 32'h40,       1, 32'h40,   0);
        tbl[9]  = mk(0, 32'h0,        0, 0, 0, 1, 0, 32'h40,       0, 32'h40,   0);
        tbl[10] = mk(0, 32'h0,        0, 0, 1, 0, 0, 32'h40,       0, 32'h40,   0);
        tbl[11] = mk(0, 32'h0,        0, 0, 0, 0, 0, 32'h40,       0, 32'h40,   0);
        tbl[12] = mk(0, 32'h0,        0, 0, 1, 0, 0, 32'h40,       0, 32'h40,   0);
        tbl[13] = mk(0, 32'h0,        0, 0, 0, 0, 1, 32'h40,       1, 32'h40,   0);
        tbl[14] = mk(0, 32'h0,        0, 0, 0, 0, 0, 32'h44,       1, 32'h40,   0);
        tbl[15] = mk(0, 32'h0,        0, 0, 1, 0, 0, 32'h44,       1, 32'h40,   0);
        tbl[16] = mk(1, 32'h2002,     0, 0, 0, 1, 0, 32'h2000,     1, 32'h40,   1);
        tbl[17] = mk(0, 32'h0,        0, 0, 0, 1, 0, 32'h2000,     0, 32'h40,   0);
        tbl[18] = mk(1, 32'h3001,     0, 0, 0, 0, 0, 32'h3000,     0, 32'h40,   1);
        tbl[19] = mk(0, 32'h0,        1, 0, 0, 0, 0, EXC_V,        1, 32'h3000, 0);
        tbl[20] = mk(0, 32'h0,        0, 0, 0, 0, 0, 32'h80000184, 1, 32'h3000, 0);
        tbl[21] = mk(1, 32'hFFFFFFFE, 0, 0, 0, 0, 0, 32'hFFFFFFFC, 1, 32'h3000, 1);
        tbl[22] = mk(0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        1, 32'h3000, 0);

        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        chk("reset.pc",    bus.pc_out,       RST_V);
        chk("reset.valid", bus.pc_valid,     1'b0);
        chk("reset.epc",   bus.pc_epc,       32'h0);
        chk("reset.mis",   bus.pc_misalign,  1'b0);
        chk("reset.empty", bus.pc_ras_empty, 1'b1);
        chk("reset.uflow", bus.pc_ras_uflow, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].wr, tbl[i].nv, tbl[i].exc, tbl[i].eret, tbl[i].stall,
                  tbl[i].halt, tbl[i].resume, tbl[i].push, tbl[i].pop);
            step();
            chk($sformatf("vec%0d.pc", i),    bus.pc_out,      tbl[i].e_pc);
            chk($sformatf("vec%0d.valid", i), bus.pc_valid,    tbl[i].e_valid);
            chk($sformatf("vec%0d.epc", i),   bus.pc_epc,      tbl[i].e_epc);
            chk($sformatf("vec%0d.mis", i),   bus.pc_misalign, tbl[i].e_mis);
        end

        // asynchronous reset between active edges
        drive(1'b1, 32'h5550, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("pre_arst.pc", bus.pc_out, 32'h5550);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst.pc",    bus.pc_out,   RST_V);
        chk("arst.valid", bus.pc_valid, 1'b0);
        chk("arst.epc",   bus.pc_epc,   32'h0);
        @(posedge clk);
        rst_n = 1'b1;
        step();
        chk("arst_boot.pc",    bus.pc_out,   RST_V);
        chk("arst_boot.valid", bus.pc_valid, 1'b1);

        if (RAS_EN) begin
            drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
            ras_step(1'b1, 1'b0, 32'h104, 1'b0, 1'b0, "ras_push1");
            ras_step(1'b0, 1'b1, 32'h108, 1'b1, 1'b0, "ras_pop1");
            ras_step(1'b1, 1'b0, 32'h10C, 1'b0, 1'b0, "ras_fill0");
            ras_step(1'b1, 1'b0, 32'h110, 1'b0, 1'b0, "ras_fill1");
            ras_step(1'b1, 1'b0, 32'h114, 1'b0, 1'b0, "ras_fill2");
            ras_step(1'b1, 1'b0, 32'h118, 1'b0, 1'b0, "ras_fill3");
            ras_step(1'b1, 1'b0, 32'h11C, 1'b0, 1'b0, "ras_fill4");
            ras_step(1'b0, 1'b1, 32'h120, 1'b0, 1'b0, "ras_drain0");
            ras_step(1'b0, 1'b1, 32'h11C, 1'b0, 1'b0, "ras_drain1");
            ras_step(1'b0, 1'b1, 32'h118, 1'b0, 1'b0, "ras_drain2");
            ras_step(1'b0, 1'b1, 32'h114, 1'b1, 1'b0, "ras_drain3");
            ras_step(1'b0, 1'b1, 32'h118, 1'b1, 1'b1, "ras_uflow");
            ras_step(1'b0, 1'b0, 32'h11C, 1'b1, 1'b0, "ras_after");
        end

        // randomized run against the reference model
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        model_reset();
        rst_n = 1'b1;
        for (int n = 0; n < 600; n++) begin
            logic wr, exc, eret, stall, halt, resume, push, pop;
            logic [31:0] nv;
            exc    = ($urandom_range(15) == 0);
            eret   = ($urandom_range(15) == 0);
            wr     = ($urandom_range(5) == 0);
            nv     = $urandom;
            stall  = ($urandom_range(3) == 0);
            halt   = ($urandom_range(11) == 0);
            resume = ($urandom_range(3) == 0);
            push   = ($urandom_range(3) == 0) && !exc && !eret;
            pop    = ($urandom_range(3) == 0);
            if (m_state == 2 && resume) wr = 1'b0;
            drive(wr, nv, exc, eret, stall, halt, resume, push, pop);
            model_edge(wr, nv, exc, eret, stall, halt, resume, push, pop);
            step();
            check_model($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
